// File: rtl/gf180mcu_fd_sc_mcu7t5v0__sdes4_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gf180mcu_fd_sc_mcu7t5v0__sdes4_pkg
//  Purpose  : Shared definitions for the sdes4 serial-in / 4-bit parallel-out
//             deserializer family (all drive strengths reuse these).
//             - WORD_W          : parallel word width (4)
//             - cnt_t           : bit-position state encodings B0..B3
//             - sdes4_assemble  : builds the output word from the three
//                                 buffered bits and the final serial bit
//  Revision : 1.0 - initial release
// ============================================================================
package gf180mcu_fd_sc_mcu7t5v0__sdes4_pkg;

    localparam int WORD_W = 4;
    localparam int CNT_W  = 2;

    // Bit position within the frame. B3 is the slot whose edge completes
    // the word; the other slots write into the partial-word buffer.
    typedef enum logic [CNT_W-1:0] {
        B0 = 2'd0,
        B1 = 2'd1,
        B2 = 2'd2,
        B3 = 2'd3
    } cnt_t;

    // The partial-word buffer always stores frame bit k at index k,
    // independent of the bit order. The order is applied only here, when
    // the word is assembled, so the capture path is identical for both
    // MSB_FIRST settings.
    function automatic logic [WORD_W-1:0] sdes4_assemble(
        input logic [WORD_W-2:0] sr,
        input logic              last_bit,
        input bit                msb_first
    );
        logic [WORD_W-1:0] word;
        if (msb_first) begin
            word = {sr[0], sr[1], sr[2], last_bit};
        end else begin
            word = {last_bit, sr[2], sr[1], sr[0]};
        end
        return word;
    endfunction

endpackage : gf180mcu_fd_sc_mcu7t5v0__sdes4_pkg
`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__sdes4_func.sv
`default_nettype none
// ============================================================================
//  Module   : gf180mcu_fd_sc_mcu7t5v0__sdes4_func
//  Purpose  : Functional model of the 4-bit deserializer: frame bit counter,
//             3-bit partial-word buffer and registered output word / strobe.
//             Shared by every drive-strength variant of the sdes4 cell.
//  Ports    :
//             VDD, VSS  inout  supply pins (USE_POWER_PINS builds only)
//             CLK       input  clock, rising-edge active
//             RN        input  asynchronous active-low reset
//             D         input  serial data, sampled when EN=1
//             EN        input  bit-valid qualifier, EN=0 holds state
//             SYNC      input  frame restart, discards a partial frame
//             Q[3:0]    output last completed word (registered)
//             QV        output one-cycle word-valid strobe (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module gf180mcu_fd_sc_mcu7t5v0__sdes4_func
    import gf180mcu_fd_sc_mcu7t5v0__sdes4_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
`ifdef USE_POWER_PINS
    inout  wire               VDD,
    inout  wire               VSS,
`endif
    input  logic              CLK,
    input  logic              RN,
    input  logic              D,
    input  logic              EN,
    input  logic              SYNC,
    output logic [WORD_W-1:0] Q,
    output logic              QV
);

    cnt_t              cnt;
    logic [WORD_W-2:0] sr;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            cnt <= B0;
            sr  <= '0;
            Q   <= '0;
            QV  <= 1'b0;
        end else begin
            // The strobe is a pulse: it only survives the edge that
            // completes a word.
            QV <= 1'b0;

            if (SYNC) begin
                // Restart wins over frame progress, including a frame that
                // would have completed on this edge: Q is left untouched.
                // The old buffer contents need no clearing because every
                // slot is rewritten before the next word is assembled.
                if (EN) begin
                    sr[0] <= D;
                    cnt   <= B1;
                end else begin
                    cnt   <= B0;
                end
            end else if (EN) begin
                unique case (cnt)
                    B0: begin
                        sr[0] <= D;
                        cnt   <= B1;
                    end
                    B1: begin
                        sr[1] <= D;
                        cnt   <= B2;
                    end
                    B2: begin
                        sr[2] <= D;
                        cnt   <= B3;
                    end
                    B3: begin
                        // The last bit bypasses the buffer so Q and QV
                        // appear on the same edge that samples it.
                        Q   <= sdes4_assemble(sr, D, MSB_FIRST);
                        QV  <= 1'b1;
                        cnt <= B0;
                    end
                    default: begin
                        cnt <= B0;
                    end
                endcase
            end
        end
    end

endmodule : gf180mcu_fd_sc_mcu7t5v0__sdes4_func
`default_nettype wire

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__sdes4_1.sv
`default_nettype none
// ============================================================================
//  Module   : gf180mcu_fd_sc_mcu7t5v0__sdes4_1
//  Purpose  : Drive-strength 1 cell of the serial-in, 4-bit parallel-out
//             deserializer. Wraps the shared functional model and adds the
//             timing arcs and checks for non-FUNCTIONAL builds.
//  Ports    :
//             VDD, VSS  inout  supply pins (USE_POWER_PINS builds only)
//             CLK       input  clock, rising-edge active
//             RN        input  asynchronous active-low reset
//             D         input  serial data, sampled when EN=1
//             EN        input  bit-valid qualifier, EN=0 holds state
//             SYNC      input  frame restart, discards a partial frame
//             Q[3:0]    output last completed word (registered)
//             QV        output one-cycle word-valid strobe (registered)
//  Revision : 1.0 - initial release
// ============================================================================
module gf180mcu_fd_sc_mcu7t5v0__sdes4_1
    import gf180mcu_fd_sc_mcu7t5v0__sdes4_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
`ifdef USE_POWER_PINS
    inout  wire               VDD,
    inout  wire               VSS,
`endif
    input  logic              CLK,
    input  logic              RN,
    input  logic              D,
    input  logic              EN,
    input  logic              SYNC,
    output logic [WORD_W-1:0] Q,
    output logic              QV
);

    gf180mcu_fd_sc_mcu7t5v0__sdes4_func #(
        .MSB_FIRST (MSB_FIRST)
    ) u_func (
`ifdef USE_POWER_PINS
        .VDD  (VDD),
        .VSS  (VSS),
`endif
        .CLK  (CLK),
        .RN   (RN),
        .D    (D),
        .EN   (EN),
        .SYNC (SYNC),
        .Q    (Q),
        .QV   (QV)
    );

`ifndef FUNCTIONAL
    specify
        // Clock-to-output arcs.
        (CLK *> Q)  = (1.0, 1.0);
        (CLK => QV) = (1.0, 1.0);

        // Reset only ever drives the outputs low, so only the assertion
        // edge carries an arc.
        (negedge RN *> Q)  = (1.0, 1.0);
        (negedge RN => QV) = (1.0, 1.0);

        // Data-side timing checks.
        $setuphold(posedge CLK, D,    0.0, 0.0);
        $setuphold(posedge CLK, EN,   0.0, 0.0);
        $setuphold(posedge CLK, SYNC, 0.0, 0.0);

        // Reset release must settle around the clock edge.
        $recrem(posedge RN, posedge CLK, 0.0, 0.0);

        // Pulse-width checks.
        $width(posedge CLK, 0.0);
        $width(negedge CLK, 0.0);
        $width(negedge RN,  0.0);
    endspecify
`endif

endmodule : gf180mcu_fd_sc_mcu7t5v0__sdes4_1
`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__sdes4_1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gf180mcu_fd_sc_mcu7t5v0__sdes4_1
//  Purpose  : Self-checking bench for the sdes4 deserializer. Two instances
//             (MSB_FIRST=1 and MSB_FIRST=0) share one stimulus stream;
//             expected words are queued when their final bit is driven and
//             popped when the matching QV strobe appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gf180mcu_fd_sc_mcu7t5v0__sdes4_1;

    logic       CLK;
    logic       RN;
    logic       D;
    logic       EN;
    logic       SYNC;
    logic [3:0] q_m;
    logic       qv_m;
    logic [3:0] q_l;
    logic       qv_l;

    int unsigned vectors;
    int unsigned miscompares;

    logic [3:0] exp_m_q[$];
    logic [3:0] exp_l_q[$];
    logic [3:0] hold_m;
    logic [3:0] hold_l;

    gf180mcu_fd_sc_mcu7t5v0__sdes4_1 #(
        .MSB_FIRST (1'b1)
    ) dut_msb (
        .CLK  (CLK),
        .RN   (RN),
        .D    (D),
        .EN   (EN),
        .SYNC (SYNC),
        .Q    (q_m),
        .QV   (qv_m)
    );

    gf180mcu_fd_sc_mcu7t5v0__sdes4_1 #(
        .MSB_FIRST (1'b0)
    ) dut_lsb (
        .CLK  (CLK),
        .RN   (RN),
        .D    (D),
        .EN   (EN),
        .SYNC (SYNC),
        .Q    (q_l),
        .QV   (qv_l)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // LSB-first word is the bit reversal of the MSB-first word.
    function automatic logic [3:0] rev4(input logic [3:0] w);
        return {w[0], w[1], w[2], w[3]};
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare one instance after an edge: strobe, then either the popped
    // scoreboard word or the held value.
    task automatic check_inst(input string name, input logic done,
                              input logic qv, input logic [3:0] q,
                              inout logic [3:0] hold, inout logic [3:0] sb[$]);
        logic [3:0] exp;
        check({name, "_qv"}, {3'b0, qv}, {3'b0, done});
        if (qv === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL %s_unexpected_word: observed %h expected none", name, q);
            end else begin
                exp = sb.pop_front();
                check({name, "_word"}, q, exp);
                hold = exp;
            end
        end else begin
            check({name, "_hold"}, q, hold);
        end
    endtask

    // One clock of stimulus. 'word' is the MSB-first value expected when
    // 'done' marks the edge that completes a frame.
    task automatic step(input logic d, input logic en, input logic sync,
                        input logic done, input logic [3:0] word);
        D    = d;
        EN   = en;
        SYNC = sync;
        if (done) begin
            exp_m_q.push_back(word);
            exp_l_q.push_back(rev4(word));
        end
        @(posedge CLK);
        #1;
        check_inst("msb", done, qv_m, q_m, hold_m, exp_m_q);
        check_inst("lsb", done, qv_l, q_l, hold_l, exp_l_q);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        hold_m      = 4'h0;
        hold_l      = 4'h0;
        RN          = 1'b0;
        D           = 1'b1;
        EN          = 1'b1;
        SYNC        = 1'b0;

        // Reset held with active-looking inputs: outputs stay cleared.
        for (int i = 0; i < 4; i++) begin
            EN = i[0];
            @(posedge CLK);
            #1;
            check("rst_q_msb",  q_m, 4'h0);
            check("rst_qv_msb", {3'b0, qv_m}, 4'h0);
            check("rst_q_lsb",  q_l, 4'h0);
            check("rst_qv_lsb", {3'b0, qv_l}, 4'h0);
        end
        RN = 1'b1;

        // First word after release: 1,0,1,1.
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'hB);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

        // Continuous stream 1,0,0,0,0,1,1,1: back-to-back words.
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'h8);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'h7);

        // EN gaps of 3 cycles between bits 1,1,0,1; D toggles in the gaps.
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'hD);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

        // SYNC mid-frame with EN=1: 1,1 discarded, new frame 0,1,0,1.
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'h5);

        // Word 0xA, then SYNC on the completing slot: no strobe, Q holds.
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'hA);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'h9);

        // SYNC with EN=0 restarts without taking a bit: new frame 0,1,1,1.
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'h7);

        // Asynchronous reset between edges after two bits of a frame.
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        RN = 1'b0;
        #1;
        check("async_q_msb",  q_m, 4'h0);
        check("async_qv_msb", {3'b0, qv_m}, 4'h0);
        check("async_q_lsb",  q_l, 4'h0);
        check("async_qv_lsb", {3'b0, qv_l}, 4'h0);
        hold_m = 4'h0;
        hold_l = 4'h0;
        #1;
        RN = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'h6);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

        // Every queued word must have been consumed by a strobe.
        check("msb_sb_drained", exp_m_q.size() == 0 ? 4'h0 : 4'h1, 4'h0);
        check("lsb_sb_drained", exp_l_q.size() == 0 ? 4'h0 : 4'h1, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global safety net so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: observed no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_gf180mcu_fd_sc_mcu7t5v0__sdes4_1
`default_nettype wire
